// File: rtl/mux_lane_pipe.sv
// Two-stage lane multiplexer: S1 captures inputs, S2 holds the selected
// lane data and the count of zeroed lanes, with valid/ready flow control.
module mux_lane_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_IN     = 16,
   parameter int NUM_LANE   = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_IN + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_IN*DATA_WIDTH-1:0]   in_vec,
   input  logic [NUM_LANE*SEL_WIDTH-1:0]  in_sel,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_LANE*DATA_WIDTH-1:0] out_data,
   output logic [$clog2(NUM_LANE+1)-1:0]  out_zero_cnt,
   output logic                           sel_err
);

   localparam int CNT_WIDTH = $clog2(NUM_LANE + 1);

   logic                           s1_valid;
   logic [NUM_IN*DATA_WIDTH-1:0]   s1_vec;
   logic [NUM_LANE*SEL_WIDTH-1:0]  s1_sel;
   logic                           s2_load;
   logic                           accept;
   logic                           bad_sel;
   logic [NUM_LANE*DATA_WIDTH-1:0] nxt_data;
   logic [CNT_WIDTH-1:0]           nxt_cnt;

   // S1 drains into S2 whenever S2 is empty or being emptied
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !reset && (!s1_valid || s2_load);
   assign accept   = in_valid && in_ready;

   // flag any incoming lane select beyond the legal zero code
   always_comb begin
      bad_sel = 1'b0;
      for (int l = 0; l < NUM_LANE; l++) begin
         if (in_sel[l*SEL_WIDTH +: SEL_WIDTH] > SEL_WIDTH'(NUM_IN))
            bad_sel = 1'b1;
      end
   end

   // per-lane decode of the S1 select; unmatched selects leave the lane zero
   always_comb begin
      nxt_data = '0;
      nxt_cnt  = '0;
      for (int l = 0; l < NUM_LANE; l++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (s1_sel[l*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(i))
               nxt_data[l*DATA_WIDTH +: DATA_WIDTH] =
                  s1_vec[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (s1_sel[l*SEL_WIDTH +: SEL_WIDTH] >= SEL_WIDTH'(NUM_IN))
            nxt_cnt = nxt_cnt + CNT_WIDTH'(1);
      end
   end

   // S1: capture accepted beats, empty when the held beat moves on
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // S1 payload only changes on acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_vec <= in_vec;
         s1_sel <= in_sel;
      end
   end

   // S2: output register, held stable while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_zero_cnt <= '0;
      end else if (s2_load) begin
         out_valid    <= 1'b1;
         out_data     <= nxt_data;
         out_zero_cnt <= nxt_cnt;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // sticky illegal-select flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err <= 1'b0;
      end else if (accept && bad_sel) begin
         sel_err <= 1'b1;
      end
   end

endmodule

// File: doc/mux_lane_pipe.md
MUX_LANE_PIPE -- requirements
Module: mux_lane_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each data element.
REQ-002 Parameter NUM_IN, default 16: number of selectable data inputs.
REQ-003 Parameter NUM_LANE, default 4: number of independent output lanes.
REQ-004 Parameter SEL_WIDTH, default $clog2(NUM_IN+1): per-lane select width.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block can accept an input beat this cycle.
REQ-009 in_vec  in  NUM_IN*DATA_WIDTH  packed inputs; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_sel  in  NUM_LANE*SEL_WIDTH  packed selects; lane l occupies bits [l*SEL_WIDTH +: SEL_WIDTH].
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts the output beat.
REQ-013 out_data  out  NUM_LANE*DATA_WIDTH  packed lane outputs, same packing as in_vec.
REQ-014 out_zero_cnt  out  $clog2(NUM_LANE+1)  number of lanes in the current beat whose select was >= NUM_IN.
REQ-015 sel_err  out  1  sticky flag: a select > NUM_IN was accepted.

Function
REQ-016 A beat is accepted when in_valid && in_ready; a beat is delivered when out_valid && out_ready.
REQ-017 Stage 1 (S1) registers in_vec and in_sel on acceptance; stage 2 (S2) registers out_data, out_zero_cnt and valid.
REQ-018 For each lane l: out_data lane = in_vec element sel_l when sel_l < NUM_IN, else all zeros; sel_l == NUM_IN is the legal "zero" code.
REQ-019 out_zero_cnt = count of lanes with sel_l >= NUM_IN for the same beat, computed in S2 alongside out_data.
REQ-020 Latency: with no backpressure, a beat accepted at edge N is presented with out_valid=1 after edge N+2.
REQ-021 Throughput: one beat per cycle sustained while out_ready=1.
REQ-022 S2 loads from S1 when S1 is valid and (S2 empty or out_ready=1); S2 clears valid on delivery with no S1 beat pending.
REQ-023 in_ready = !S1_valid || S1 advancing this cycle; in_ready is a combinational function of state and out_ready only, never of in_valid.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_zero_cnt are held stable and no beat is dropped or duplicated.
REQ-025 Simultaneous accept and S1 advance in one cycle overwrites S1 with the new beat; order of beats is preserved.
REQ-026 sel_err sets on the edge after acceptance of any beat with some sel_l > NUM_IN and stays 1 until reset; such lanes output zero and count in out_zero_cnt.
REQ-027 in_vec/in_sel are ignored when the beat is not accepted.

Reset
REQ-028 While reset=1 at a posedge: S1 and S2 valid cleared, out_valid=0, out_data=0, out_zero_cnt=0, sel_err=0.
REQ-029 Reset mid-operation discards all in-flight beats; the first beat after reset deasserts is accepted normally (in_ready=1 in the cycle after reset).
REQ-030 in_ready is 0 while reset is asserted.

Verification
REQ-031 Defaults, in_vec element i = i+1, in_sel lanes {0,5,15,16}, out_ready=1 -> two cycles later out_data lanes {1,6,16,0}, out_zero_cnt=1, sel_err=0.
REQ-032 Stream 8 beats back-to-back, out_ready=1 -> 8 consecutive out_valid cycles, data in order, in_ready held 1.
REQ-033 out_ready=0 for 5 cycles during streaming -> in_ready falls after at most 2 beats buffered, out_data stable, no loss or duplication after out_ready returns to 1.
REQ-034 Lane select 20 (> NUM_IN) -> that lane 0, counted in out_zero_cnt, sel_err=1 and held through later legal beats until reset.
REQ-035 Reset asserted with both stages full -> next cycle out_valid=0, all outputs 0, sel_err=0; a new beat then appears after 2 cycles.
REQ-036 Parameter sweep NUM_IN=4, NUM_LANE=1, DATA_WIDTH=16 -> select 4 gives 0, select 3 gives element 3, select 5 sets sel_err.
